// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU slice: op codes, FSM states, helpers.
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int OP_W  = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Codes above SLTU are reserved and flagged as errors.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit integer ALU: op, a, b -> result, err.
// Bitwise functions come from the gate-level units; reserved codes give 0 with err.
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] result,
    output logic             err
);

    logic [ALU_W-1:0] and_s;
    logic [ALU_W-1:0] or_s;
    logic [ALU_W-1:0] xor_s;
    logic [4:0]       shamt_s;

    and_32bit u_and (.a(a), .b(b), .y(and_s));
    or_32bit  u_or  (.a(a), .b(b), .y(or_s));
    xor_32bit u_xor (.a(a), .b(b), .y(xor_s));

    assign shamt_s = b[4:0];

    // Select the function result for the current op code.
    always_comb begin
        result = 32'd0;
        err    = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = and_s;
            ALU_OR:   result = or_s;
            ALU_XOR:  result = xor_s;
            ALU_SLL:  result = a << shamt_s;
            ALU_SRL:  result = a >> shamt_s;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt_s);
            ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {31'd0, (a < b)};
            default: begin
                result = 32'd0;
                err    = !op_is_legal(op);
            end
        endcase
    end

endmodule

// File: rtl/and_32bit.sv
// 32-bit bitwise AND gate unit.
module and_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

// File: rtl/or_32bit.sv
// 32-bit bitwise OR gate unit.
module or_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

// File: rtl/xor_32bit.sv
// 32-bit bitwise XOR gate unit.
module xor_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// Sequence per operation: IDLE (grant+latch) -> EXEC (compute) -> RESP (hold result).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_err,
    output logic             busy
);

    state_t           state_r;
    logic             last_grant_r;
    logic             owner_r;
    logic [OP_W-1:0]  op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             rsp0_valid_r;
    logic             rsp1_valid_r;
    logic [WIDTH-1:0] rsp0_result_r;
    logic [WIDTH-1:0] rsp1_result_r;
    logic             rsp0_err_r;
    logic             rsp1_err_r;
    logic             busy_r;

    logic             grant0_s;
    logic             grant1_s;
    logic             rsp_take_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_err_s;

    alu_core u_core (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .result (alu_result_s),
        .err    (alu_err_s)
    );

    // Grant decision: only in IDLE; a tie goes to the requester not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign rsp_take_s = owner_r ? rsp1_ready : rsp0_ready;

    // Arbiter FSM with operand latches and per-requester response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= 1'b1;
            owner_r       <= 1'b0;
            op_r          <= 4'd0;
            a_r           <= 32'd0;
            b_r           <= 32'd0;
            rsp0_valid_r  <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp0_result_r <= 32'd0;
            rsp1_result_r <= 32'd0;
            rsp0_err_r    <= 1'b0;
            rsp1_err_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        op_r    <= grant1_s ? req1_op : req0_op;
                        a_r     <= grant1_s ? req1_a  : req0_a;
                        b_r     <= grant1_s ? req1_b  : req0_b;
                        owner_r <= grant1_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (owner_r) begin
                        rsp1_result_r <= alu_result_s;
                        rsp1_err_r    <= alu_err_s;
                        rsp1_valid_r  <= 1'b1;
                    end else begin
                        rsp0_result_r <= alu_result_s;
                        rsp0_err_r    <= alu_err_s;
                        rsp0_valid_r  <= 1'b1;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        last_grant_r <= owner_r;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign rsp0_valid  = rsp0_valid_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp0_result = rsp0_result_r;
    assign rsp1_result = rsp1_result_r;
    assign rsp0_err    = rsp0_err_r;
    assign rsp1_err    = rsp1_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, reset corner cases,
// then randomized traffic against a behavioural reference model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_err, rsp1_err, busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: who was served last and each port's last delivered response.
    logic        model_lg;
    logic [31:0] last_res [2];
    logic        last_err [2];

    typedef struct {
        logic        v0, v1;
        logic [3:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        int          hold;
        logic        own;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t tbl [17];

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Behavioural ALU: returns {err, result}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        int sa, sb;
        logic [31:0] r;
        s  = b % 32;
        sa = a;
        sb = b;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << s;
            4'd6: r = a >> s;
            4'd7: begin
                r = a >> s;
                if (a[31]) r = r | ~(32'hFFFFFFFF >> s);
            end
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    task automatic model_reset();
        model_lg    = 1'b1;
        last_res[0] = 32'd0;
        last_res[1] = 32'd0;
        last_err[0] = 1'b0;
        last_err[1] = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk1({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
        chk1({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_quiet("reset");
        chk32("reset_rsp0_result", rsp0_result, 32'd0);
        chk32("reset_rsp1_result", rsp1_result, 32'd0);
        chk1("reset_rsp0_err", rsp0_err, 1'b0);
        chk1("reset_rsp1_err", rsp1_err, 1'b0);
    endtask

    // One full operation; the loser (if any) keeps valid high throughout.
    task automatic run_txn(input logic v0, input logic v1, input logic [3:0] op0, input logic [3:0] op1,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input int hold, input logic own, input logic [31:0] res, input logic err);
        logic [31:0] own_res, oth_res;
        logic        own_err, oth_err;
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk1("grant0", req0_ready, !own);
        chk1("grant1", req1_ready, own);
        chk1("idle_busy", busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        if (own) req1_valid = 1'b0; else req0_valid = 1'b0;
        rsp0_ready = own ? 1'b1 : (hold == 0);
        rsp1_ready = own ? (hold == 0) : 1'b1;
        #1;
        chk1("exec_busy", busy, 1'b1);
        chk1("exec_req0_ready", req0_ready, 1'b0);
        chk1("exec_req1_ready", req1_ready, 1'b0);
        chk1("exec_rsp0_valid", rsp0_valid, 1'b0);
        chk1("exec_rsp1_valid", rsp1_valid, 1'b0);
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            #1;
            own_res = own ? rsp1_result : rsp0_result;
            own_err = own ? rsp1_err : rsp0_err;
            oth_res = own ? rsp0_result : rsp1_result;
            oth_err = own ? rsp0_err : rsp1_err;
            chk1("resp_rsp0_valid", rsp0_valid, !own);
            chk1("resp_rsp1_valid", rsp1_valid, own);
            chk32("resp_result", own_res, res);
            chk1("resp_err", own_err, err);
            chk32("other_result_hold", oth_res, last_res[!own]);
            chk1("other_err_hold", oth_err, last_err[!own]);
            chk1("resp_req0_ready", req0_ready, 1'b0);
            chk1("resp_req1_ready", req1_ready, 1'b0);
            chk1("resp_busy", busy, 1'b1);
            if (k == hold) begin
                if (own) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        check_quiet("done");
        last_res[own] = res;
        last_err[own] = err;
        model_lg = own;
    endtask

    initial begin
        logic        v0, v1, own;
        logic [3:0]  op0, op1;
        logic [31:0] a0, b0, a1, b1;
        logic [32:0] r;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 4'd0; req1_op = 4'd0;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        model_reset();

        //          v0    v1    op0    op1    a0            b0            a1            b1         hold own   result        err
        tbl[0]  = '{1'b1, 1'b0, 4'd0,  4'd0,  32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        0, 1'b0, 32'h00000001, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'd0,  4'd7,  32'h0,        32'h0,        32'h80000000, 32'h00000024, 0, 1'b1, 32'hF8000000, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'd0,  4'd1,  32'h10,       32'h20,       32'h5,        32'h7,        0, 1'b0, 32'h00000030, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 4'd0,  4'd1,  32'h10,       32'h20,       32'h5,        32'h7,        0, 1'b1, 32'hFFFFFFFE, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'd0,  4'd1,  32'h10,       32'h20,       32'h5,        32'h7,        0, 1'b0, 32'h00000030, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'd0,  4'd1,  32'h10,       32'h20,       32'h5,        32'h7,        0, 1'b1, 32'hFFFFFFFE, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'd0,  4'd8,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000001, 0, 1'b1, 32'h00000001, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'd0,  4'd9,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000001, 0, 1'b1, 32'h00000000, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 4'd3,  4'd4,  32'h12340000, 32'h00005678, 32'hA5A5A5A5, 32'hFFFF0000, 5, 1'b0, 32'h12345678, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 4'd3,  4'd4,  32'h12340000, 32'h00005678, 32'hA5A5A5A5, 32'hFFFF0000, 0, 1'b1, 32'h5A5AA5A5, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 4'd12, 4'd0,  32'hDEADBEEF, 32'h00000001, 32'h0,        32'h0,        0, 1'b0, 32'h00000000, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 4'd2,  4'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h0,        0, 1'b0, 32'h00F000F0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 4'd5,  4'd0,  32'h00000001, 32'h0000003F, 32'h0,        32'h0,        1, 1'b0, 32'h80000000, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'd0,  4'd6,  32'h0,        32'h0,        32'h80000000, 32'h0000001F, 0, 1'b1, 32'h00000001, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 4'd15, 4'd10, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 1'b0, 32'h00000000, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 4'd8,  4'd0,  32'h80000000, 32'h7FFFFFFF, 32'h0,        32'h0,        2, 1'b0, 32'h00000001, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 4'd0,  4'd1,  32'h0,        32'h0,        32'h00000000, 32'h00000001, 0, 1'b1, 32'hFFFFFFFF, 1'b0};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_txn(tbl[i].v0, tbl[i].v1, tbl[i].op0, tbl[i].op1, tbl[i].a0, tbl[i].b0,
                    tbl[i].a1, tbl[i].b1, tbl[i].hold, tbl[i].own, tbl[i].res, tbl[i].err);
        end

        // Reset while in EXEC discards the operation.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'h1; req0_b = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_quiet("rst_exec");
        chk32("rst_exec_rsp0_result", rsp0_result, 32'd0);

        // Reset while in RESP drops the pending response.
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'h9; req1_b = 32'h2;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk1("pre_rst_rsp1_valid", rsp1_valid, 1'b1);
        chk32("pre_rst_rsp1_result", rsp1_result, 32'h00000007);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_quiet("rst_resp");
        chk32("rst_resp_rsp1_result", rsp1_result, 32'd0);

        // First tie after reset goes to req0.
        run_txn(1'b1, 1'b1, 4'd4, 4'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h1, 32'h1,
                0, 1'b0, 32'hF00FF00F, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            v0  = 1'($urandom_range(0, 1));
            v1  = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v1 = 1'b1;
            op0 = 4'($urandom_range(0, 11));
            op1 = 4'($urandom_range(0, 11));
            a0  = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            if (i % 4 == 0) a0 = 32'h80000000 | a0;
            own = (v0 && v1) ? !model_lg : v1;
            r   = own ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
            run_txn(v0, v1, op0, op1, a0, b0, a1, b1, int'($urandom_range(0, 2)), own, r[31:0], r[32]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
